nibble_add_seq: RTL



---
 rtl/nibble_add_seq_if.sv | 38 +++
 rtl/nibble_add_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add_seq_if
//  Description : Request/result bundle for the nibble-serial adder.
//                The master drives the request (start, a, b); the slave
//                returns status (busy, done) and the result (sum, cout).
//  Ports       : start  - request, honoured only while the sequencer is idle
//                a, b   - W-bit operands, W = 4*NIBBLES
//                busy   - nibbles are being added
//                done   - one-cycle completion pulse
//                sum    - W-bit result, (a+b) mod 2^W
//                cout   - carry out of the top nibble
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add_seq
//  Description : Wide unsigned adder built from one shared 4-bit slice.
//                Operands are captured on an accepted start, then one nibble
//                is added per clock, least-significant first, with the carry
//                chained between nibbles. A one-cycle done pulse marks the
//                final sum/cout.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-high, wins over start
//                bus  - nibble_add_seq_if slave (start, a, b in;
//                       busy, done, sum, cout out)
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  nibble_add_seq_if.slave     bus
);

  localparam int W     = 4 * NIBBLES;
  // Counter needs at least one bit even when there is a single nibble.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int IDX_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state;
  logic [W-1:0]       r_a, w_a;
  logic [W-1:0]       r_b, w_b;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_carry, w_carry;
  logic [W-1:0]       r_sum, w_sum;
  logic               r_cout, w_cout;

  // Bit offset of the active nibble: cnt*4.
  logic [IDX_W-1:0]   w_idx;
  // Shared 4-bit slice: {carry_out, nibble_sum}.
  logic [4:0]         w_nib;

  assign w_idx = {r_cnt, 2'b00};
  assign w_nib = {1'b0, r_a[w_idx +: 4]} + {1'b0, r_b[w_idx +: 4]} + {4'd0, r_carry};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_cnt   <= w_cnt;
      r_carry <= w_carry;
      r_sum   <= w_sum;
      r_cout  <= w_cout;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_cnt   = r_cnt;
    w_carry = r_carry;
    w_sum   = r_sum;
    w_cout  = r_cout;

    case (r_state)
      S_IDLE: begin
        // Without start every register holds, so the last result stays visible.
        if (bus.start) begin
          w_a     = bus.a;
          w_b     = bus.b;
          w_cnt   = '0;
          w_carry = 1'b0;
          w_sum   = '0;
          w_cout  = 1'b0;
          w_state = S_ADD;
        end
      end

      S_ADD: begin
        w_sum[w_idx +: 4] = w_nib[3:0];
        w_carry           = w_nib[4];
        if (r_cnt == C_LAST) begin
          w_cout  = w_nib[4];
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Status decoded from registered state only; no input-to-output path.
  assign bus.busy = (r_state == S_ADD);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire
